// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared types for the fetch controller (FAULT state only with FETCH_MISALIGN_TRAP_EN)
package instr_fetch_ctrl_pkg;

    localparam int INSTR_BYTES = 4;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] instr_t;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, HALT, FAULT} fetch_state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, HALT} fetch_state_t;
`endif

endpackage

// File: rtl/instr_fetch_ctrl_buffer.sv
// rtl/instr_fetch_ctrl_buffer.sv - two-entry {pc, instr} FIFO with flush
module fetch_buffer
    import instr_fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  addr_t      push_pc,
    input  instr_t     push_instr,
    input  logic       pop,
    output logic       out_valid,
    output addr_t      head_pc,
    output instr_t     head_instr,
    output logic [1:0] count
);

    addr_t  pc_mem    [2];
    instr_t instr_mem [2];
    logic   wr_ptr;
    logic   rd_ptr;
    logic   do_push;
    logic   do_pop;

    // A full buffer still accepts a push when the head leaves on the same edge
    assign do_pop     = pop && (count != 2'd0);
    assign do_push    = push && ((count != 2'd2) || do_pop);
    assign out_valid  = (count != 2'd0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    // Storage, pointers and occupancy; flush wins over push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_mem[0]    <= '0;
            pc_mem[1]    <= '0;
            instr_mem[0] <= '0;
            instr_mem[1] <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction fetch FSM and pc; FETCH_MISALIGN_TRAP_EN adds the misaligned-redirect trap
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          MEM_BYTES = 12
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] inst_address,
    input  logic [31:0] instruction_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        halted
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fault
`endif
);

    localparam addr_t STEP       = addr_t'(INSTR_BYTES);
    localparam addr_t MEM_LIMIT  = addr_t'(MEM_BYTES);
    localparam addr_t ALIGN_MASK = STEP - 64'd1;

    fetch_state_t state;
    addr_t        pc;
    addr_t        pc_inc;
    logic [1:0]   count;
    logic         in_range;
    logic         pop;
    logic         push;
    logic         take_redirect;
    logic         trap;

    assign inst_address = pc;
    assign pc_inc       = pc + STEP;
    assign in_range     = (pc_inc <= MEM_LIMIT);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Once trapped, redirects are ignored until reset
    assign take_redirect = redirect_valid && (state != FAULT);
    assign trap          = take_redirect && ((redirect_pc & ALIGN_MASK) != 64'd0);
`else
    assign take_redirect = redirect_valid;
    assign trap          = 1'b0;
`endif

    // A redirect cycle neither consumes nor produces an instruction
    assign pop    = out_valid && out_ready && !redirect_valid;
    assign push   = (state == FETCH) && in_range && !redirect_valid
                    && ((count != 2'd2) || pop);
    assign halted = (state == HALT) && (count == 2'd0);

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rst        (reset),
        .flush      (take_redirect),
        .push       (push),
        .push_pc    (pc),
        .push_instr (instruction_in),
        .pop        (pop),
        .out_valid  (out_valid),
        .head_pc    (out_pc),
        .head_instr (out_instr),
        .count      (count)
    );

    // Fetch sequencing: start, redirect, pc advance and end-of-memory halt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault <= 1'b0;
`endif
        end else if (take_redirect) begin
            if (trap) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                state <= FAULT;
                fault <= 1'b1;
`endif
            end else begin
                state <= FETCH;
                pc    <= redirect_pc & ~ALIGN_MASK;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (push) begin
                        pc <= pc_inc;
                        if ((pc_inc + STEP) > MEM_LIMIT) begin
                            state <= HALT;
                        end
                    end else if (!in_range) begin
                        state <= HALT;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule
